// File: rtl/fsm_seq_multi.sv
// fsm_seq_multi: per-channel debounced Idle/Start/Stop/Clear sequence monitor with pulse outputs and saturating done counters
module fsm_seq_multi #(
  parameter int CH    = 4,
  parameter int HOLD  = 2,
  parameter int CNT_W = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                En,
  input  logic                clr_cnt,
  input  logic [CH-1:0]       A,
  output logic [CH-1:0]       K1,
  output logic [CH-1:0]       K2,
  output logic [2*CH-1:0]     state,
  output logic [CNT_W*CH-1:0] done_cnt
);
  typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, STOP = 2'b10, CLEAR = 2'b11} st_t;
  localparam int FW = HOLD > 1 ? $clog2(HOLD) : 1;
  localparam logic [FW-1:0] FMAX = FW'(HOLD - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    st_t st;
    logic af, k1, k2;
    logic [FW-1:0] fc;
    logic [CNT_W-1:0] cnt;
    logic adv;
    // The ring advances on af=1 from even states and af=0 from odd states; Clear+1 wraps to Idle
    assign adv = st[0] ? !af : af;
    // Filter, sequence walk, pulses and counter; clr_cnt ignores En and beats a coincident increment
    always_ff @(posedge Clock) begin
      if (Reset) begin
        st  <= IDLE;
        af  <= 1'b0;
        fc  <= '0;
        k1  <= 1'b0;
        k2  <= 1'b0;
        cnt <= '0;
      end else begin
        if (En) begin
          if (A[i] == af) fc <= '0;
          else if (fc == FMAX) begin
            af <= A[i];
            fc <= '0;
          end else fc <= fc + 1'b1;
          st <= adv ? st_t'(st + 2'd1) : st;
          k2 <= st == STOP && af;
          k1 <= st == CLEAR && !af;
          if (st == CLEAR && !af && cnt != CMAX) cnt <= cnt + 1'b1;
        end else begin
          k1 <= 1'b0;
          k2 <= 1'b0;
        end
        if (clr_cnt) cnt <= '0;
      end
    end
    assign state[2*i +: 2]            = st;
    assign done_cnt[CNT_W*i +: CNT_W] = cnt;
    assign K1[i]                      = k1;
    assign K2[i]                      = k2;
  end
endmodule

// File: tb/tb_fsm_seq_multi.sv
// tb_fsm_seq_multi: directed checks of reset, sequencing, glitch rejection, saturation, freeze and mid-sequence reset
module tb_fsm_seq_multi;
  localparam int CH = 4, HOLD = 2, CNT_W = 2;
  logic Clock = 1'b0, Reset = 1'b1, En = 1'b1, clr_cnt = 1'b0;
  logic [CH-1:0] A = '1, K1, K2;
  logic [2*CH-1:0] state;
  logic [CNT_W*CH-1:0] done_cnt;
  int compared = 0, mismatched = 0;
  always #5 Clock = ~Clock;
  fsm_seq_multi #(.CH(CH), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .En(En), .clr_cnt(clr_cnt), .A(A),
    .K1(K1), .K2(K2), .state(state), .done_cnt(done_cnt)
  );
  task automatic tick;
    @(posedge Clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [1:0] st(input int c);
    return state[2*c +: 2];
  endfunction
  function automatic logic [CNT_W-1:0] cn(input int c);
    return done_cnt[CNT_W*c +: CNT_W];
  endfunction
  // Drive one level on channel c for five cycles; the state moves on the third edge
  task automatic lvl(input int c, input logic v, input logic [1:0] es, input logic ek1, input logic ek2);
    logic [1:0] p;
    p = es - 2'd1;
    A[c] = v;
    tick;
    tick;
    chk($sformatf("hold_ch%0d_%0b", c, es), {30'd0, st(c)}, {30'd0, p});
    tick;
    chk($sformatf("state_ch%0d_%0b", c, es), {30'd0, st(c)}, {30'd0, es});
    chk($sformatf("pulse_ch%0d_%0b", c, es), {30'd0, K1[c], K2[c]}, {30'd0, ek1, ek2});
    tick;
    chk($sformatf("pulse_off_ch%0d_%0b", c, es), {30'd0, K1[c], K2[c]}, 32'd0);
    tick;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_state", {24'd0, state}, 32'd0);
    chk("rst_k", {24'd0, K1, K2}, 32'd0);
    chk("rst_cnt", {24'd0, done_cnt}, 32'd0);
    Reset = 1'b0;
    A = 4'b0001;
    tick;
    tick;
    chk("rel_idle", {30'd0, st(0)}, 32'd0);
    tick;
    chk("rel_start", {30'd0, st(0)}, 32'd1);
    tick;
    tick;
    lvl(0, 1'b0, 2'b10, 1'b0, 1'b0);
    lvl(0, 1'b1, 2'b11, 1'b0, 1'b1);
    lvl(0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("seq_cnt0", {30'd0, cn(0)}, 32'd1);
    chk("others_idle", {26'd0, state[7:2]}, 32'd0);
    A[1] = 1'b1;
    tick;
    A[1] = 1'b0;
    tick;
    tick;
    tick;
    tick;
    chk("glitch_idle", {30'd0, st(1)}, 32'd0);
    A[1] = 1'b1;
    tick;
    tick;
    A[1] = 1'b0;
    tick;
    chk("glitch_start", {30'd0, st(1)}, 32'd1);
    tick;
    tick;
    chk("ch1_stop", {30'd0, st(1)}, 32'd2);
    for (int k = 0; k < 5; k++) begin
      lvl(2, 1'b1, 2'b01, 1'b0, 1'b0);
      lvl(2, 1'b0, 2'b10, 1'b0, 1'b0);
      lvl(2, 1'b1, 2'b11, 1'b0, 1'b1);
      lvl(2, 1'b0, 2'b00, 1'b1, 1'b0);
      chk($sformatf("sat_cnt2_%0d", k), {30'd0, cn(2)}, k < 3 ? k + 1 : 3);
    end
    lvl(2, 1'b1, 2'b01, 1'b0, 1'b0);
    lvl(2, 1'b0, 2'b10, 1'b0, 1'b0);
    lvl(2, 1'b1, 2'b11, 1'b0, 1'b1);
    A[2] = 1'b0;
    tick;
    tick;
    clr_cnt = 1'b1;
    tick;
    clr_cnt = 1'b0;
    chk("clr_state2", {30'd0, st(2)}, 32'd0);
    chk("clr_k1_2", {31'd0, K1[2]}, 32'd1);
    chk("clr_cnt2", {30'd0, cn(2)}, 32'd0);
    chk("clr_cnt0", {30'd0, cn(0)}, 32'd0);
    tick;
    tick;
    lvl(3, 1'b1, 2'b01, 1'b0, 1'b0);
    lvl(3, 1'b0, 2'b10, 1'b0, 1'b0);
    En = 1'b0;
    A[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      chk($sformatf("freeze_%0d", k), {29'd0, st(3), K2[3]}, 32'b100);
    end
    En = 1'b1;
    tick;
    tick;
    chk("resume_stop", {30'd0, st(3)}, 32'd2);
    tick;
    chk("resume_clear", {29'd0, st(3), K2[3]}, 32'b111);
    tick;
    chk("resume_k2_off", {31'd0, K2[3]}, 32'd0);
    lvl(0, 1'b1, 2'b01, 1'b0, 1'b0);
    lvl(0, 1'b0, 2'b10, 1'b0, 1'b0);
    lvl(0, 1'b1, 2'b11, 1'b0, 1'b1);
    A[0] = 1'b0;
    tick;
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    chk("mid_rst_state", {30'd0, st(0)}, 32'd0);
    chk("mid_rst_k1", {31'd0, K1[0]}, 32'd0);
    chk("mid_rst_cnt", {24'd0, done_cnt}, 32'd0);
    tick;
    tick;
    tick;
    chk("post_rst_idle", {30'd0, st(0), 1'b0, K1[0]} >> 1, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
